wb_stage: RTL and testbench

Parametrised, pipelined write-back stage for the RISC-V core: replaces the purely combinational write-back mux with a registered stage. It formats load data by size, sign and byte offset, and selects among ALU result, load data, PC+4 and set-less-than. It delivers one register-file write per instruction over a valid/ready port, and a 2-entry skid buffer absorbs register-file back-pressure without a combinational ready path.

---
 rtl/wb_pkg.sv | 30 +++
 rtl/wb_load_fmt.sv | 49 ++++
 rtl/wb_stage.sv | 138 +++++++++++++
 tb/tb_wb_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared write-back definitions: select/size encodings, buffer states and the buffered entry.
package wb_pkg;

    localparam logic [1:0] WSEL_RES  = 2'b00;
    localparam logic [1:0] WSEL_LOAD = 2'b01;
    localparam logic [1:0] WSEL_PC4  = 2'b10;
    localparam logic [1:0] WSEL_SLT  = 2'b11;

    localparam logic [1:0] WHB_B = 2'b00;
    localparam logic [1:0] WHB_H = 2'b01;
    localparam logic [1:0] WHB_W = 2'b10;
    localparam logic [1:0] WHB_D = 2'b11;

    // Entry fields are sized for the widest legal configuration; narrower builds use the low bits.
    localparam int WB_XLEN_MAX = 64;
    localparam int WB_RAW_MAX  = 8;

    typedef struct packed {
        logic [WB_RAW_MAX-1:0]  rd;
        logic                   we;
        logic [WB_XLEN_MAX-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } wb_state_e;

endpackage

// File: rtl/wb_load_fmt.sv
// Load formatter: extracts the byte/half/word/double lane at the load offset and sign/zero-extends it.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// A double request on a 32-bit datapath yields the full word.
module wb_load_fmt
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] read_data,
    input  logic [2:0]      offset,
    input  logic [1:0]      whb,
    input  logic            su,
    output logic [XLEN-1:0] load_data
);

    localparam int LW = $clog2(XLEN);

    logic [2:0]      eff_off;
    logic [5:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [LW-1:0]   msb;
    logic            ext_bit;
    logic            unused_off_hi;

    assign unused_off_hi = offset[2];
    assign eff_off = (XLEN == 32) ? {1'b0, offset[1:0]} : offset;
    assign shamt   = {eff_off, 3'b000};
    assign shifted = read_data >> shamt;

    always_comb begin
        msb = LW'(XLEN - 1);
        case (whb)
            WHB_B:   msb = LW'(7);
            WHB_H:   msb = LW'(15);
            WHB_W:   msb = LW'(31);
            default: msb = LW'(XLEN - 1);
        endcase
    end

    assign ext_bit = su & shifted[msb];

    always_comb begin
        load_data = '0;
        for (int i = 0; i < XLEN; i++) begin
            load_data[i] = (i > int'(msb)) ? ext_bit : shifted[i];
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Registered write-back stage with a 2-entry skid buffer feeding the register-file write port.
// Latency: 1 cycle from accept to rf_* when EMPTY or draining. Backpressure: in_ready = state != FULL, no rf_ready path.
// WB_RETIRE_CNT_EN adds a 64-bit retire_cnt output counting every drain.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]     retire_cnt,
`endif
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RAW-1:0]  in_rd,
    input  logic            in_we,
    input  logic [1:0]      in_wsel,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_read_data,
    input  logic [2:0]      in_offset,
    input  logic [XLEN-1:0] in_pc4,
    input  logic            in_su,
    input  logic [1:0]      in_whb,
    input  logic            in_lt,
    input  logic            in_ltu,
    input  logic            in_slt_u,
    output logic            rf_valid,
    input  logic            rf_ready,
    output logic [RAW-1:0]  rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            rf_we
);

    wb_state_e       state_q, state_d;
    wb_entry_t       in_entry, out_q, skid_q;
    logic [XLEN-1:0] load_data, wdata;
    logic            accept, drain;
    logic            load_out, load_skid, out_from_skid;
    logic            unused_entry_bits;

    wb_load_fmt #(.XLEN(XLEN)) u_load_fmt (
        .read_data (in_read_data),
        .offset    (in_offset),
        .whb       (in_whb),
        .su        (in_su),
        .load_data (load_data)
    );

    always_comb begin
        wdata = in_result;
        case (in_wsel)
            WSEL_LOAD: wdata = load_data;
            WSEL_PC4:  wdata = in_pc4;
            WSEL_SLT: begin
                wdata    = '0;
                wdata[0] = in_slt_u ? in_ltu : in_lt;
            end
            default:   wdata = in_result;
        endcase
        in_entry                = '0;
        in_entry.rd[RAW-1:0]    = in_rd;
        in_entry.we             = in_we;
        in_entry.data[XLEN-1:0] = wdata;
    end

    assign in_ready = (state_q != ST_FULL);
    assign rf_valid = (state_q != ST_EMPTY);
    assign accept   = in_valid & in_ready;
    assign drain    = rf_valid & rf_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: if (accept) begin
                state_d  = ST_ONE;
                load_out = 1'b1;
            end
            ST_ONE: begin
                if (accept && !drain) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (accept) begin
                    load_out = 1'b1;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: if (drain) begin
                state_d       = ST_ONE;
                out_from_skid = 1'b1;
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush overrides any accept/drain in the same cycle.
        if (flush) begin
            state_d       = ST_EMPTY;
            load_out      = 1'b0;
            load_skid     = 1'b0;
            out_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out)           out_q <= in_entry;
            else if (out_from_skid) out_q <= skid_q;
            if (load_skid)          skid_q <= in_entry;
        end
    end

    assign rf_waddr = out_q.rd[RAW-1:0];
    assign rf_wdata = out_q.data[XLEN-1:0];
    assign rf_we    = rf_valid & out_q.we & (out_q.rd[RAW-1:0] != '0);

    assign unused_entry_bits = ^{out_q, skid_q};

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 retire_cnt <= '0;
        else if (drain && !flush) retire_cnt <= retire_cnt + 64'd1;
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: scoreboard of expected writes checked on each drain, plus
// directed checks for reset, back-pressure, flush, async reset and a 64-bit instance.
module tb_wb_stage;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic        in_we = 1'b0;
    logic [1:0]  in_wsel = '0;
    logic [31:0] in_result = '0, in_read_data = '0, in_pc4 = '0;
    logic [2:0]  in_offset = '0;
    logic        in_su = 1'b0, in_lt = 1'b0, in_ltu = 1'b0, in_slt_u = 1'b0;
    logic [1:0]  in_whb = '0;
    logic        rf_valid, rf_we;
    logic        rf_ready = 1'b1;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic        x_in_valid = 1'b0, x_in_ready, x_rf_valid, x_rf_we;
    logic        x_rf_ready = 1'b1;
    logic [4:0]  x_rf_waddr;
    logic [63:0] x_read_data = '0, x_rf_wdata;
    logic [1:0]  x_whb = '0;
    logic        x_su = 1'b0;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt, x_retire_cnt, cnt_before;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .RAW(5)) dut (
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_we(in_we), .in_wsel(in_wsel), .in_result(in_result),
        .in_read_data(in_read_data), .in_offset(in_offset), .in_pc4(in_pc4), .in_su(in_su),
        .in_whb(in_whb), .in_lt(in_lt), .in_ltu(in_ltu), .in_slt_u(in_slt_u),
        .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_we(rf_we)
    );

    wb_stage #(.XLEN(64), .RAW(5)) dut64 (
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt(x_retire_cnt),
`endif
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .in_rd(5'd9), .in_we(1'b1), .in_wsel(2'b01), .in_result(64'd0),
        .in_read_data(x_read_data), .in_offset(3'd0), .in_pc4(64'd0), .in_su(x_su),
        .in_whb(x_whb), .in_lt(1'b0), .in_ltu(1'b0), .in_slt_u(1'b0),
        .rf_valid(x_rf_valid), .rf_ready(x_rf_ready), .rf_waddr(x_rf_waddr), .rf_wdata(x_rf_wdata),
        .rf_we(x_rf_we)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drains are checked against the scoreboard just before the edge that completes them.
    always @(negedge clk) begin
        if (!rst && rf_valid && rf_ready && !flush) begin
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_waddr", 64'(rf_waddr), 64'(e.rd));
                check("sb_we",    64'(rf_we),    64'(e.we));
                check("sb_wdata", 64'(rf_wdata), 64'(e.data));
            end
        end
    end

    task automatic set_in(input logic [4:0] rd, input logic we, input logic [1:0] wsel,
                          input logic [31:0] result, input logic [2:0] off, input logic su,
                          input logic [1:0] whb, input logic slt_u);
        in_rd = rd; in_we = we; in_wsel = wsel; in_result = result;
        in_offset = off; in_su = su; in_whb = whb; in_slt_u = slt_u;
    endtask

    // Offer the current inputs until accepted, pushing the expected write on acceptance.
    task automatic send(input logic [31:0] exp_data);
        int n;
        exp_t e;
        n = 0;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_timeout", 64'(in_ready), 64'd1);
        e.rd = in_rd; e.we = in_we && (in_rd != 0); e.data = exp_data;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1;
        check("rst_rf_valid", 64'(rf_valid), 64'd0);
        check("rst_rf_we",    64'(rf_we),    64'd0);
        check("rst_waddr",    64'(rf_waddr), 64'd0);
        check("rst_wdata",    64'(rf_wdata), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef WB_RETIRE_CNT_EN
        check("rst_cnt", retire_cnt, 64'd0);
`endif
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Loads from 0x80FF7F01
        in_read_data = 32'h80FF7F01;
        set_in(5'd1, 1'b1, 2'b01, 32'd0, 3'd1, 1'b1, 2'b00, 1'b0);
        send(32'h0000007F);
        check("latency_one_cycle", 64'(rf_valid), 64'd1);
        check("latency_data", 64'(rf_wdata), 64'h7F);
        set_in(5'd2, 1'b1, 2'b01, 32'd0, 3'd3, 1'b1, 2'b00, 1'b0); send(32'hFFFFFF80);
        set_in(5'd3, 1'b1, 2'b01, 32'd0, 3'd2, 1'b0, 2'b01, 1'b0); send(32'h000080FF);
        set_in(5'd4, 1'b1, 2'b01, 32'd0, 3'd0, 1'b1, 2'b11, 1'b0); send(32'h80FF7F01);
        set_in(5'd5, 1'b1, 2'b01, 32'd0, 3'd4, 1'b0, 2'b00, 1'b0); send(32'h00000001);

        // Source select
        in_pc4 = 32'h8; in_lt = 1'b0; in_ltu = 1'b1;
        set_in(5'd6, 1'b1, 2'b00, 32'd200, 3'd0, 1'b0, 2'b10, 1'b0); send(32'd200);
        set_in(5'd7, 1'b1, 2'b10, 32'd200, 3'd0, 1'b0, 2'b10, 1'b0); send(32'h8);
        set_in(5'd8, 1'b1, 2'b11, 32'd200, 3'd0, 1'b0, 2'b10, 1'b1); send(32'd1);
        set_in(5'd9, 1'b1, 2'b11, 32'd200, 3'd0, 1'b0, 2'b10, 1'b0); send(32'd0);
        wait_empty();

        // Back-pressure: three back-to-back entries with rf_ready low
        rf_ready = 1'b0;
        set_in(5'd10, 1'b1, 2'b00, 32'hA, 3'd0, 1'b0, 2'b10, 1'b0); send(32'hA);
        check("bp_ready_after_first", 64'(in_ready), 64'd1);
        set_in(5'd11, 1'b1, 2'b00, 32'hB, 3'd0, 1'b0, 2'b10, 1'b0); send(32'hB);
        check("bp_ready_after_second", 64'(in_ready), 64'd0);
        set_in(5'd12, 1'b1, 2'b00, 32'hC, 3'd0, 1'b0, 2'b10, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bp_hold_ready", 64'(in_ready), 64'd0);
        check("bp_hold_data", 64'(rf_wdata), 64'hA);
        check("bp_hold_addr", 64'(rf_waddr), 64'd10);
        rf_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_second_out", 64'(rf_wdata), 64'hB);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        begin
            exp_t e;
            e.rd = 5'd12; e.we = 1'b1; e.data = 32'hC;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_third_out", 64'(rf_wdata), 64'hC);
        check("bp_third_valid", 64'(rf_valid), 64'd1);
        @(posedge clk); #1;
        check("bp_empty_after", 64'(rf_valid), 64'd0);
        wait_empty();

        // x0 and no-write entries still occupy and drain a slot
`ifdef WB_RETIRE_CNT_EN
        cnt_before = retire_cnt;
`endif
        set_in(5'd0, 1'b1, 2'b00, 32'h55, 3'd0, 1'b0, 2'b10, 1'b0); send(32'h55);
        check("x0_valid", 64'(rf_valid), 64'd1);
        check("x0_we",    64'(rf_we),    64'd0);
        set_in(5'd4, 1'b0, 2'b00, 32'h66, 3'd0, 1'b0, 2'b10, 1'b0); send(32'h66);
        check("nowe_we", 64'(rf_we), 64'd0);
        wait_empty();
        @(posedge clk); #1;
`ifdef WB_RETIRE_CNT_EN
        check("x0_cnt", retire_cnt, cnt_before + 64'd2);
`endif

        // Flush with a full buffer and a new entry offered in the same cycle
        rf_ready = 1'b0;
        set_in(5'd13, 1'b1, 2'b00, 32'hD, 3'd0, 1'b0, 2'b10, 1'b0); send(32'hD);
        set_in(5'd14, 1'b1, 2'b00, 32'hE, 3'd0, 1'b0, 2'b10, 1'b0); send(32'hE);
        check("fl_full", 64'(in_ready), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        cnt_before = retire_cnt;
`endif
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        exp_q.delete();
        check("fl_rf_valid", 64'(rf_valid), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        rf_ready = 1'b1;
        @(posedge clk); #1;
        check("fl_stays_empty", 64'(rf_valid), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        check("fl_cnt", retire_cnt, cnt_before);
`endif

        // Asynchronous reset while full
        rf_ready = 1'b0;
        set_in(5'd15, 1'b1, 2'b00, 32'hF, 3'd0, 1'b0, 2'b10, 1'b0); send(32'hF);
        set_in(5'd16, 1'b1, 2'b00, 32'h10, 3'd0, 1'b0, 2'b10, 1'b0); send(32'h10);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_rf_valid", 64'(rf_valid), 64'd0);
        check("arst_rf_we",    64'(rf_we),    64'd0);
        check("arst_waddr",    64'(rf_waddr), 64'd0);
        check("arst_wdata",    64'(rf_wdata), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
`ifdef WB_RETIRE_CNT_EN
        check("arst_cnt", retire_cnt, 64'd0);
`endif
        @(negedge clk); rst = 1'b0;
        rf_ready = 1'b1;
        @(posedge clk); #1;

        // 64-bit instance: double passes through, word at offset 0 sign-extends
        x_read_data = 64'h0123456789ABCDEF; x_whb = 2'b11; x_su = 1'b1; x_in_valid = 1'b1;
        @(posedge clk); #1;
        check("x64_double", x_rf_wdata, 64'h0123456789ABCDEF);
        check("x64_valid", 64'(x_rf_valid), 64'd1);
        x_whb = 2'b10;
        @(posedge clk); #1;
        x_in_valid = 1'b0;
        check("x64_word_sext", x_rf_wdata, 64'hFFFFFFFF89ABCDEF);
        check("x64_we", 64'(x_rf_we), 64'd1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
